// File: rtl/ifetch_pkg.sv
// Shared definitions for the Y86 fetch unit: FSM states, icode values,
// instruction length constants and a byte-field helper.
package ifetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_STOP  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_5 = 3'd5;
    localparam logic [2:0] LEN_6 = 3'd6;

    function automatic logic [3:0] icode_of(input logic [7:0] b);
        return b[7:4];
    endfunction

endpackage

// File: rtl/ifetch_len.sv
// Combinational icode decoder: instruction length in bytes and illegal flag.
module ifetch_len
    import ifetch_pkg::*;
(
    input  logic [3:0] icode,
    output logic [2:0] len,
    output logic       illegal
);

    // Length lookup; unknown icodes become 1-byte illegal instructions
    always_comb begin
        len     = LEN_1;
        illegal = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET:              len = LEN_1;
            I_RRMOVL, I_OPL, I_PUSHL, I_POPL:  len = LEN_2;
            I_JXX, I_CALL:                     len = LEN_5;
            I_IRMOVL, I_RMMOVL, I_MRMOVL:      len = LEN_6;
            default: begin
                len     = LEN_1;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// Y86 instruction fetch: byte-serial memory reads packed into a whole
// instruction, presented to decode with valid/ready, with redirect and halt.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              MAX_LEN  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic [PC_W-1:0]      mem_addr,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ack,
    input  logic                 redirect,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic [PC_W-1:0]      pc_o,
    output logic [8*MAX_LEN-1:0] inst_o,
    output logic [2:0]           inst_len,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 inst_err,
    output logic                 halted
);

    localparam int INST_W = 8 * MAX_LEN;

    state_t              state_r, state_s;
    logic [2:0]          byte_cnt_r, byte_cnt_s;
    logic [2:0]          len_r, len_s;
    logic [INST_W-1:0]   inst_r, inst_s;
    logic [PC_W-1:0]     pc_r, pc_s;
    logic [PC_W-1:0]     addr_r, addr_s;
    logic                req_r, req_s;
    logic                valid_r, valid_s;
    logic                err_r, err_s;
    logic                halted_r, halted_s;

    logic [2:0]          dec_len_s;
    logic                dec_ill_s;
    logic [2:0]          cur_len_s;
    logic                xfer_s;
    logic                accept_s;

    ifetch_len u_len (
        .icode   (icode_of(mem_rdata)),
        .len     (dec_len_s),
        .illegal (dec_ill_s)
    );

    assign xfer_s    = req_r && mem_ack;
    assign accept_s  = valid_r && ready_i;
    // Length is only known once byte 0 arrives; later bytes use the stored value
    assign cur_len_s = (byte_cnt_r == 3'd0) ? dec_len_s : len_r;

    // Next-state and next-output logic; redirect overrides everything else
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        len_s      = len_r;
        inst_s     = inst_r;
        pc_s       = pc_r;
        addr_s     = addr_r;
        req_s      = req_r;
        valid_s    = valid_r;
        err_s      = err_r;
        halted_s   = halted_r;
        if (redirect) begin
            pc_s       = redirect_pc;
            valid_s    = 1'b0;
            halted_s   = 1'b0;
            byte_cnt_s = 3'd0;
            inst_s     = '0;
            err_s      = 1'b0;
            // An outstanding request cannot be withdrawn: drain it in FLUSH
            if (req_r && !mem_ack) begin
                state_s = ST_FLUSH;
            end else begin
                state_s = ST_FETCH;
                req_s   = 1'b1;
                addr_s  = redirect_pc;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_FETCH;
                    req_s   = 1'b1;
                    addr_s  = pc_r;
                end
                ST_FETCH: begin
                    if (xfer_s) begin
                        inst_s = inst_r | ({mem_rdata, {(INST_W-8){1'b0}}} >> {byte_cnt_r, 3'b000});
                        if (byte_cnt_r == 3'd0) begin
                            len_s = dec_len_s;
                            err_s = dec_ill_s;
                        end else begin
                            len_s = len_r;
                        end
                        if (byte_cnt_r == cur_len_s - 3'd1) begin
                            state_s    = ST_HOLD;
                            req_s      = 1'b0;
                            valid_s    = 1'b1;
                            byte_cnt_s = 3'd0;
                        end else begin
                            byte_cnt_s = byte_cnt_r + 3'd1;
                            addr_s     = pc_r + PC_W'(byte_cnt_r + 3'd1);
                        end
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        valid_s = 1'b0;
                        inst_s  = '0;
                        err_s   = 1'b0;
                        if (err_r || (icode_of(inst_r[INST_W-1 -: 8]) == I_HALT)) begin
                            state_s  = ST_STOP;
                            halted_s = 1'b1;
                        end else begin
                            state_s = ST_FETCH;
                            pc_s    = pc_r + PC_W'(len_r);
                            req_s   = 1'b1;
                            addr_s  = pc_r + PC_W'(len_r);
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_STOP: begin
                    halted_s = 1'b1;
                    req_s    = 1'b0;
                end
                ST_FLUSH: begin
                    if (mem_ack) begin
                        state_s = ST_FETCH;
                        addr_s  = pc_r;
                    end else begin
                        state_s = ST_FLUSH;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    req_s   = 1'b0;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 3'd0;
            len_r      <= 3'd0;
            inst_r     <= '0;
            pc_r       <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            len_r      <= len_s;
            inst_r     <= inst_s;
            pc_r       <= pc_s;
            addr_r     <= addr_s;
            req_r      <= req_s;
            valid_r    <= valid_s;
            err_r      <= err_s;
            halted_r   <= halted_s;
        end
    end

    assign mem_req  = req_r;
    assign mem_addr = addr_r;
    assign pc_o     = pc_r;
    assign inst_o   = inst_r;
    assign inst_len = len_r;
    assign valid_o  = valid_r;
    assign inst_err = err_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: byte memory model with optional random ack
// stalls, hand-computed instruction/PC expectations.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_o;
    logic [47:0] inst_o;
    logic [2:0]  inst_len;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        inst_err;
    logic        halted;

    logic [7:0]  mem [0:255];
    logic        dir_ack = 1'b1;
    logic        rnd_ack = 1'b1;
    logic        stall_mode = 1'b0;
    logic        xfer_seen = 1'b0;
    int          wait_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    ifetch dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc_o(pc_o), .inst_o(inst_o),
        .inst_len(inst_len), .valid_o(valid_o), .ready_i(ready_i),
        .inst_err(inst_err), .halted(halted)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_ack   = stall_mode ? rnd_ack : dir_ack;

    always @(posedge clk) xfer_seen <= mem_req && mem_ack;

    // Random 0-3 cycle wait before each transfer while stall mode is on
    always @(negedge clk) begin
        if (stall_mode) begin
            if (xfer_seen) wait_cnt = $urandom_range(0, 3);
            rnd_ack = (wait_cnt == 0);
            if (wait_cnt > 0) wait_cnt = wait_cnt - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_valid", 64'(valid_o), 64'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    task automatic fetch_one(input string tag, input logic [31:0] epc,
                             input logic [47:0] einst, input logic [2:0] elen, input logic eerr);
        wait_valid();
        check_eq({tag, "_pc"},   64'(pc_o),     64'(epc));
        check_eq({tag, "_inst"}, 64'(inst_o),   64'(einst));
        check_eq({tag, "_len"},  64'(inst_len), 64'(elen));
        check_eq({tag, "_err"},  64'(inst_err), 64'(eerr));
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check_eq({tag, "_drop"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h30; mem[8'h01] = 8'hF3; mem[8'h02] = 8'h78;
        mem[8'h03] = 8'h56; mem[8'h04] = 8'h34; mem[8'h05] = 8'h12;
        mem[8'h06] = 8'h10; mem[8'h07] = 8'h10; mem[8'h08] = 8'h00;
        mem[8'h10] = 8'hF0;
        for (int i = 0; i < 6; i++) mem[8'h20 + i] = mem[i];
        mem[8'h26] = 8'h61; mem[8'h27] = 8'h23; mem[8'h28] = 8'h00;
        mem[8'h30] = 8'h20; mem[8'h31] = 8'h12;
        mem[8'h40] = 8'h20; mem[8'h41] = 8'h34; mem[8'h42] = 8'h00;
        mem[8'h50] = 8'h10; mem[8'h51] = 8'h00;

        @(negedge clk);
        check_eq("rst_req",   64'(mem_req),  64'd0);
        check_eq("rst_out",   64'({valid_o, halted, inst_err, inst_len, inst_o}), 64'd0);
        check_eq("rst_pc",    64'({pc_o, mem_addr}), 64'd0);
        rst = 1'b1;

        // Zero-wait 6-byte irmovl: one address per cycle, valid at cycle 7
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 6) check_eq("seq_addr", 64'({mem_req, valid_o, mem_addr}), 64'({2'b10, 32'(c - 1)}));
            else        check_eq("seq_valid", 64'({mem_req, valid_o}), 64'b01);
        end
        check_eq("irmovl_inst", 64'(inst_o), 64'h30F378563412);
        check_eq("irmovl_len_pc", 64'({inst_len, pc_o}), 64'({3'd6, 32'h0}));

        // Backpressure: nothing moves while ready_i is low
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("hold", 64'({valid_o, mem_req, inst_o}), 64'({2'b10, 48'h30F378563412}));
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check_eq("accept_next", 64'({valid_o, mem_req, mem_addr}), 64'({2'b01, 32'h6}));
        check_eq("accept_clr", 64'(inst_o), 64'd0);

        fetch_one("nop6", 32'h6, 48'h100000000000, 3'd1, 1'b0);
        fetch_one("nop7", 32'h7, 48'h100000000000, 3'd1, 1'b0);
        fetch_one("halt8", 32'h8, 48'h0, 3'd1, 1'b0);
        check_eq("halted", 64'({halted, mem_req}), 64'b10);
        repeat (3) @(negedge clk);
        check_eq("stop_idle", 64'({halted, mem_req, valid_o}), 64'b100);

        // Illegal icode: 1-byte error instruction then stop
        pulse_redirect(32'h10);
        check_eq("redir_resume", 64'({halted, mem_req, mem_addr}), 64'({2'b01, 32'h10}));
        fetch_one("ill", 32'h10, 48'hF00000000000, 3'd1, 1'b1);
        check_eq("ill_halt", 64'(halted), 64'd1);

        // Random memory stalls must not change packing or PCs
        stall_mode = 1'b1;
        pulse_redirect(32'h20);
        fetch_one("st_irm", 32'h20, 48'h30F378563412, 3'd6, 1'b0);
        fetch_one("st_opl", 32'h26, 48'h612300000000, 3'd2, 1'b0);
        fetch_one("st_hlt", 32'h28, 48'h0, 3'd1, 1'b0);
        stall_mode = 1'b0;
        dir_ack    = 1'b1;

        // Redirect while byte 1 is outstanding: request held, byte discarded
        pulse_redirect(32'h30);
        check_eq("fl_a0", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h30}));
        @(negedge clk);
        dir_ack = 1'b0;
        check_eq("fl_a1", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h31}));
        @(negedge clk);
        pulse_redirect(32'h40);
        check_eq("fl_hold", 64'({mem_req, mem_addr, pc_o}), 64'({1'b1, 32'h31, 32'h40}));
        @(negedge clk);
        check_eq("fl_hold2", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h31}));
        dir_ack = 1'b1;
        @(negedge clk);
        check_eq("fl_new", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h40}));
        wait_valid();
        check_eq("fl_inst", 64'({inst_o, inst_len}), 64'({48'h203400000000, 3'd2}));
        check_eq("fl_pc", 64'(pc_o), 64'h40);

        // Redirect in the same cycle as accept wins
        ready_i = 1'b1;
        pulse_redirect(32'h50);
        ready_i = 1'b0;
        check_eq("ra_state", 64'({valid_o, mem_req, mem_addr, pc_o[7:0]}), 64'({2'b01, 32'h50, 8'h50}));
        fetch_one("ra_nop", 32'h50, 48'h100000000000, 3'd1, 1'b0);
        fetch_one("ra_hlt", 32'h51, 48'h0, 3'd1, 1'b0);

        // Reset in the middle of a fetch
        pulse_redirect(32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mr_req", 64'({mem_req, valid_o, halted, inst_err}), 64'd0);
        check_eq("mr_regs", 64'({mem_addr, pc_o}), 64'd0);
        check_eq("mr_inst", 64'({inst_o, inst_len}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        fetch_one("mr_irm", 32'h0, 48'h30F378563412, 3'd6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
